i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 189 ++++++++++++++++++
 tb/tb_i2c_target.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target with a 16-bit register pointer: write sets the pointer then streams data,
// read streams bytes from rd_data starting at the current pointer.
module i2c_target #(
  parameter logic [6:0]  DEVICE_ADDR     = 7'h29,
  parameter int unsigned CLK_PER_SCL_MIN = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        SCL_in,
  input  logic        SDA_in,
  output logic        SDA_oe,
  output logic [15:0] reg_addr,
  output logic [7:0]  wr_data,
  output logic        wr_valid,
  input  logic [7:0]  rd_data,
  output logic        rd_req,
  output logic        busy,
  output logic        nack_err
);

  localparam int unsigned SYNC_LAT = 3;

  // Each SCL quarter period must outlast the synchronizer so SDA_oe settles while SCL is low.
  if (CLK_PER_SCL_MIN < 4 * SYNC_LAT) begin : g_param_check
    $error("CLK_PER_SCL_MIN too small for the input synchronizer latency");
  end

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REGH, REGH_ACK, REGL, REGL_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_e;

  // [0] metastability flop, [1] synchronized level, [2] history for edge detect
  logic [2:0] scl_pipe_q, sda_pipe_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_pipe_q <= 3'b111;
      sda_pipe_q <= 3'b111;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
      scl_pipe_q <= {scl_pipe_q[1:0], SCL_in};
      sda_pipe_q <= {sda_pipe_q[1:0], SDA_in};
    end
  end

  logic scl_sync, sda_sync, scl_rise, scl_fall, start_det, stop_det;
  assign scl_sync  = scl_pipe_q[1];
  assign sda_sync  = sda_pipe_q[1];
  assign scl_rise  =  scl_sync & ~scl_pipe_q[2];
  assign scl_fall  = ~scl_sync &  scl_pipe_q[2];
  assign start_det =  sda_pipe_q[2] & ~sda_sync & scl_sync;
  assign stop_det  = ~sda_pipe_q[2] &  sda_sync & scl_sync;

  state_e      state_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q, reg_hi_q, wr_data_q;
  logic [15:0] reg_addr_q;
  logic        sda_oe_q, wr_valid_q, rd_req_q, busy_q, nack_err_q;

  logic [7:0] byte_in;
  logic       in_byte_state, cut_short;
  assign byte_in       = {shift_q[6:0], sda_sync};
  assign in_byte_state = (state_q == REGH) || (state_q == REGL) ||
                         (state_q == WDATA) || (state_q == RDATA);
  // The SCL-high period carrying a START/STOP already bumped the count once,
  // so only a count above one means real data bits were lost.
  assign cut_short     = in_byte_state && (bit_cnt_q > 4'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      reg_hi_q   <= 8'h00;
      wr_data_q  <= 8'h00;
      reg_addr_q <= 16'h0000;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      nack_err_q <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      if (stop_det) begin
        if (cut_short) nack_err_q <= 1'b1;
        state_q   <= IDLE;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        bit_cnt_q <= 4'd0;
      end else if (start_det) begin
        if (cut_short) nack_err_q <= 1'b1;
        state_q   <= ADDR;
        sda_oe_q  <= 1'b0;
        bit_cnt_q <= 4'd0;
      end else begin
        unique case (state_q)
          IDLE, WAIT_STOP: ;
          ADDR, REGH, REGL, WDATA: begin
            if (scl_rise && bit_cnt_q != 4'd8) begin
              shift_q   <= byte_in;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                if (state_q == REGH) reg_hi_q <= byte_in;
                if (state_q == REGL) reg_addr_q <= {reg_hi_q, byte_in};
                if (state_q == WDATA) begin
                  wr_data_q  <= byte_in;
                  wr_valid_q <= 1'b1;
                end
              end
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= 4'd0;
              if (state_q == ADDR && shift_q[7:1] != DEVICE_ADDR) begin
                state_q <= WAIT_STOP;
                busy_q  <= 1'b0;
              end else begin
                sda_oe_q <= 1'b1;
                unique case (state_q)
                  ADDR:    begin state_q <= ADDR_ACK; busy_q <= 1'b1; end
                  REGH:    state_q <= REGH_ACK;
                  REGL:    state_q <= REGL_ACK;
                  default: state_q <= WDATA_ACK;
                endcase
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            bit_cnt_q <= 4'd0;
            if (shift_q[0]) begin
              shift_q  <= rd_data;
              rd_req_q <= 1'b1;
              sda_oe_q <= ~rd_data[7];
              state_q  <= RDATA;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= REGH;
            end
          end
          REGH_ACK: if (scl_fall) begin sda_oe_q <= 1'b0; state_q <= REGL; end
          REGL_ACK: if (scl_fall) begin sda_oe_q <= 1'b0; state_q <= WDATA; end
          WDATA_ACK: if (scl_fall) begin
            sda_oe_q   <= 1'b0;
            reg_addr_q <= reg_addr_q + 16'd1;
            state_q    <= WDATA;
          end
          RDATA: begin
            if (scl_rise && bit_cnt_q != 4'd8) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= 4'd0;
              sda_oe_q  <= 1'b0;
              state_q   <= RDATA_ACK;
            end else if (scl_fall && bit_cnt_q != 4'd0) begin
              shift_q  <= {shift_q[6:0], 1'b0};
              sda_oe_q <= ~shift_q[6];
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_sync) begin
                state_q <= WAIT_STOP;
                busy_q  <= 1'b0;
              end else begin
                reg_addr_q <= reg_addr_q + 16'd1;
              end
            end else if (scl_fall) begin
              // Only reachable after an ACK; the pointer already advanced on the ACK sample.
              shift_q  <= rd_data;
              rd_req_q <= 1'b1;
              sda_oe_q <= ~rd_data[7];
              state_q  <= RDATA;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign SDA_oe   = sda_oe_q;
  assign reg_addr = reg_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;
  assign nack_err = nack_err_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C controller drives an open-drain bus model.
module tb_i2c_target;

  localparam int Q = 6;   // clocks from SCL edge to data change / next edge
  localparam int H = 12;  // clocks SCL is held high

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        scl_lvl = 1'b1;
  logic        m_sda_low = 1'b0;
  logic        SDA_oe, wr_valid, rd_req, busy, nack_err;
  logic [15:0] reg_addr;
  logic [7:0]  wr_data, rd_data;
  logic        sda_bus;

  assign sda_bus = ~(SDA_oe | m_sda_low);
  assign rd_data = reg_addr[7:0];

  always #5 clock = ~clock;

  i2c_target dut (
    .clock   (clock),
    .reset   (reset),
    .SCL_in  (scl_lvl),
    .SDA_in  (sda_bus),
    .SDA_oe  (SDA_oe),
    .reg_addr(reg_addr),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .rd_data (rd_data),
    .rd_req  (rd_req),
    .busy    (busy),
    .nack_err(nack_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] wr_addr_log[$];
  logic [7:0]  wr_data_log[$];
  int rd_cnt = 0, oe_cnt = 0, busy_cnt = 0, oe_hi_viol = 0, both_cnt = 0;
  logic oe_prev = 1'b0;

  always @(posedge clock) begin
    #1;
    if (!reset) begin
      if (wr_valid) begin
        wr_addr_log.push_back(reg_addr);
        wr_data_log.push_back(wr_data);
      end
      if (rd_req) rd_cnt++;
      if (wr_valid && rd_req) both_cnt++;
      if (SDA_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (SDA_oe != oe_prev && scl_lvl) oe_hi_viol++;
    end
    oe_prev = SDA_oe;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic i2c_start;
    m_sda_low = 1'b1; idle(H);
    scl_lvl = 1'b0;   idle(Q);
  endtask

  task automatic i2c_rstart;
    m_sda_low = 1'b0; idle(Q);
    scl_lvl = 1'b1;   idle(H / 2);
    m_sda_low = 1'b1; idle(H / 2);
    scl_lvl = 1'b0;   idle(Q);
  endtask

  task automatic i2c_stop;
    m_sda_low = 1'b1; idle(Q);
    scl_lvl = 1'b1;   idle(H / 2);
    m_sda_low = 1'b0; idle(H / 2);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; idle(Q);
    scl_lvl = 1'b1; idle(H);
    scl_lvl = 1'b0; idle(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; idle(Q);
    scl_lvl = 1'b1;   idle(H / 2);
    b = sda_bus;      idle(H / 2);
    scl_lvl = 1'b0;   idle(Q);
  endtask

  task automatic write_byte(input logic [7:0] data, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(data[i]);
    read_bit(b);
    acked = ~b;
  endtask

  task automatic read_byte(output logic [7:0] data, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      data[i] = b;
    end
    write_bit(~master_ack);
  endtask

  initial begin
    logic       ack, dummy;
    logic [7:0] d;
    int w0, r0, o0, b0;

    idle(4);
    reset = 1'b0;
    idle(2);
    check("rst SDA_oe", SDA_oe, 0);
    check("rst reg_addr", reg_addr, 16'h0000);
    check("rst wr_data", wr_data, 8'h00);
    check("rst busy", busy, 0);
    check("rst nack_err", nack_err, 0);

    // Write: pointer 0x0016, data A5, 3C
    w0 = wr_addr_log.size();
    i2c_start;
    write_byte(8'h52, ack); check("t1 addr ack", ack, 1);
    check("t1 busy", busy, 1);
    write_byte(8'h00, ack); check("t1 regh ack", ack, 1);
    write_byte(8'h16, ack); check("t1 regl ack", ack, 1);
    write_byte(8'hA5, ack); check("t1 d0 ack", ack, 1);
    write_byte(8'h3C, ack); check("t1 d1 ack", ack, 1);
    i2c_stop;
    check("t1 wr count", wr_addr_log.size() - w0, 2);
    check("t1 wr0 addr", wr_addr_log[w0], 16'h0016);
    check("t1 wr0 data", wr_data_log[w0], 8'hA5);
    check("t1 wr1 addr", wr_addr_log[w0+1], 16'h0017);
    check("t1 wr1 data", wr_data_log[w0+1], 8'h3C);
    check("t1 reg_addr", reg_addr, 16'h0018);
    check("t1 busy end", busy, 0);
    check("t1 nack_err", nack_err, 0);

    // Pointer 0x010F, repeated START, read two bytes (ACK then NACK)
    w0 = wr_addr_log.size(); r0 = rd_cnt;
    i2c_start;
    write_byte(8'h52, ack); check("t2 addr ack", ack, 1);
    write_byte(8'h01, ack); check("t2 regh ack", ack, 1);
    write_byte(8'h0F, ack); check("t2 regl ack", ack, 1);
    i2c_rstart;
    write_byte(8'h53, ack); check("t2 raddr ack", ack, 1);
    read_byte(d, 1'b1);     check("t2 rd byte0", d, 8'h0F);
    read_byte(d, 1'b0);     check("t2 rd byte1", d, 8'h10);
    check("t2 rd_req count", rd_cnt - r0, 2);
    check("t2 reg_addr", reg_addr, 16'h0110);
    check("t2 busy after nack", busy, 0);
    check("t2 SDA_oe after nack", SDA_oe, 0);
    i2c_stop;
    check("t2 no wr_valid", wr_addr_log.size() - w0, 0);
    check("t2 nack_err", nack_err, 0);

    // Wrong address 0x2A: fully ignored until the next START
    w0 = wr_addr_log.size(); r0 = rd_cnt; o0 = oe_cnt; b0 = busy_cnt;
    i2c_start;
    write_byte(8'h54, ack); check("t3 addr nack", ack, 0);
    write_byte(8'hA5, ack); check("t3 byte nack", ack, 0);
    write_byte(8'h00, ack);
    i2c_stop;
    check("t3 SDA_oe never", oe_cnt - o0, 0);
    check("t3 busy never", busy_cnt - b0, 0);
    check("t3 no wr_valid", wr_addr_log.size() - w0, 0);
    check("t3 no rd_req", rd_cnt - r0, 0);

    // Pointer wrap 0xFFFF -> 0x0000
    w0 = wr_addr_log.size();
    i2c_start;
    write_byte(8'h52, ack);
    write_byte(8'hFF, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack); check("t4 d0 ack", ack, 1);
    write_byte(8'h22, ack); check("t4 d1 ack", ack, 1);
    i2c_stop;
    check("t4 wr count", wr_addr_log.size() - w0, 2);
    check("t4 wr0 addr", wr_addr_log[w0], 16'hFFFF);
    check("t4 wr0 data", wr_data_log[w0], 8'h11);
    check("t4 wr1 addr", wr_addr_log[w0+1], 16'h0000);
    check("t4 wr1 data", wr_data_log[w0+1], 8'h22);
    check("t4 reg_addr", reg_addr, 16'h0001);

    // STOP after four data bits
    w0 = wr_addr_log.size();
    i2c_start;
    write_byte(8'h52, ack);
    write_byte(8'h00, ack);
    write_byte(8'h40, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop;
    check("t5 nack_err", nack_err, 1);
    check("t5 no wr_valid", wr_addr_log.size() - w0, 0);
    check("t5 busy", busy, 0);
    check("t5 SDA_oe", SDA_oe, 0);
    check("t5 reg_addr", reg_addr, 16'h0040);

    // Reset while the REGH byte is being ACKed
    i2c_start;
    write_byte(8'h52, ack);
    for (int i = 7; i >= 0; i--) write_bit(1'(8'h12 >> i));
    check("t6 ack driven", SDA_oe, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("t6 SDA_oe released", SDA_oe, 0);
    check("t6 reg_addr", reg_addr, 16'h0000);
    check("t6 nack_err", nack_err, 0);
    @(negedge clock);
    reset = 1'b0;
    w0 = wr_addr_log.size(); r0 = rd_cnt; o0 = oe_cnt; b0 = busy_cnt;
    read_bit(dummy);
    write_byte(8'h34, ack); check("t6 ignored ack", ack, 0);
    write_byte(8'h56, ack);
    check("t6 SDA_oe idle", oe_cnt - o0, 0);
    check("t6 busy idle", busy_cnt - b0, 0);
    check("t6 no pulses", (wr_addr_log.size() - w0) + (rd_cnt - r0), 0);
    i2c_stop;

    // Recovery with a fresh START
    w0 = wr_addr_log.size();
    i2c_start;
    write_byte(8'h52, ack);
    write_byte(8'h00, ack);
    write_byte(8'h05, ack);
    write_byte(8'h77, ack); check("t6 recover ack", ack, 1);
    i2c_stop;
    check("t6 recover count", wr_addr_log.size() - w0, 1);
    check("t6 recover addr", wr_addr_log[w0], 16'h0005);
    check("t6 recover data", wr_data_log[w0], 8'h77);

    check("SDA_oe change while SCL high", oe_hi_viol, 0);
    check("wr_valid with rd_req", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
